bridge_tx: RTL and testbench



---
 rtl/bridge_pkg.sv | 18 +
 rtl/bridge_tx_hex_encoder.sv | 12 +
 rtl/bridge_tx.sv | 173 +++++++++++++++++
 tb/tb_bridge_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge_tx response serializer.
// Frame layout: 'M', four hex digits MSB-first, CR, LF.
package bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [2:0] idx_t;

    localparam logic [7:0] ASCII_M   = 8'h4D;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam int         FRAME_LEN = 7;
    localparam idx_t       LAST_IDX  = idx_t'(FRAME_LEN - 1);

endpackage

// File: rtl/bridge_tx_hex_encoder.sv
// Combinational nibble-to-ASCII converter producing uppercase hex digits.
module hex_encoder (
    input  logic [3:0] i_nib,
    output logic [7:0] o_asc
);

    always_comb begin
        if (i_nib < 4'd10) o_asc = 8'h30 + {4'h0, i_nib};
        else               o_asc = 8'h37 + {4'h0, i_nib};
    end

endmodule

// File: rtl/bridge_tx.sv
// Turns completed bus reads into 7-byte ASCII frames on a valid/ready byte stream.
// Define BRIDGE_TX_PENDING_EN to add a one-entry pending slot for colliding reads.
module bridge_tx
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        overflow_o
);

    state_t      r_state;
    idx_t        r_idx;
    logic [15:0] r_data;
    logic [7:0]  r_byte;
    logic        r_valid;
    logic        r_busy;
    logic        r_ovf;

    logic        w_cap;
    logic        w_xfer;
    logic        w_last;
    logic        w_drop;
    state_t      w_nxt_state;
    idx_t        w_nxt_idx;
    logic [15:0] w_nxt_data;
    logic [3:0]  w_nib;
    logic [7:0]  w_hex;
    logic [7:0]  w_nxt_byte;

`ifdef BRIDGE_TX_PENDING_EN
    logic        r_pend_vld;
    logic [15:0] r_pend_data;
    logic        w_nxt_pend_vld;
    logic [15:0] w_nxt_pend_data;
`endif

    assign w_cap  = valid_i && !rw_i;
    assign w_xfer = r_valid && ready_i;
    assign w_last = w_xfer && (r_idx == LAST_IDX);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_data  = r_data;
        w_drop      = 1'b0;
`ifdef BRIDGE_TX_PENDING_EN
        w_nxt_pend_vld  = r_pend_vld;
        w_nxt_pend_data = r_pend_data;
`endif
        case (r_state)
            IDLE: begin
                if (w_cap) begin
                    w_nxt_state = SEND;
                    w_nxt_idx   = '0;
                    w_nxt_data  = data_i;
                end
            end
            SEND: begin
                if (w_last) begin
`ifdef BRIDGE_TX_PENDING_EN
                    // The held entry is older, so it goes first; a same-cycle read refills the slot.
                    if (r_pend_vld) begin
                        w_nxt_idx       = '0;
                        w_nxt_data      = r_pend_data;
                        w_nxt_pend_vld  = w_cap;
                        w_nxt_pend_data = w_cap ? data_i : r_pend_data;
                    end else if (w_cap) begin
                        w_nxt_idx  = '0;
                        w_nxt_data = data_i;
                    end else begin
                        w_nxt_state = IDLE;
                    end
`else
                    if (w_cap) begin
                        w_nxt_idx  = '0;
                        w_nxt_data = data_i;
                    end else begin
                        w_nxt_state = IDLE;
                    end
`endif
                end else begin
                    if (w_xfer) w_nxt_idx = idx_t'(r_idx + 3'd1);
                    if (w_cap) begin
`ifdef BRIDGE_TX_PENDING_EN
                        if (!r_pend_vld) begin
                            w_nxt_pend_vld  = 1'b1;
                            w_nxt_pend_data = data_i;
                        end else begin
                            w_drop = 1'b1;
                        end
`else
                        w_drop = 1'b1;
`endif
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Encode the byte for the next cycle so data_o comes straight from a flop.
    always_comb begin
        case (w_nxt_idx)
            3'd1:    w_nib = w_nxt_data[15:12];
            3'd2:    w_nib = w_nxt_data[11:8];
            3'd3:    w_nib = w_nxt_data[7:4];
            3'd4:    w_nib = w_nxt_data[3:0];
            default: w_nib = 4'h0;
        endcase
    end

    hex_encoder u_hex (
        .i_nib (w_nib),
        .o_asc (w_hex)
    );

    always_comb begin
        w_nxt_byte = 8'h00;
        if (w_nxt_state == SEND) begin
            case (w_nxt_idx)
                3'd0:    w_nxt_byte = ASCII_M;
                3'd5:    w_nxt_byte = ASCII_CR;
                3'd6:    w_nxt_byte = ASCII_LF;
                default: w_nxt_byte = w_hex;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_data  <= w_nxt_data;
            r_byte  <= w_nxt_byte;
            r_valid <= (w_nxt_state == SEND);
            r_busy  <= (w_nxt_state == SEND);
            r_ovf   <= r_ovf | w_drop;
        end
    end

`ifdef BRIDGE_TX_PENDING_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
        end else begin
            r_pend_vld  <= w_nxt_pend_vld;
            r_pend_data <= w_nxt_pend_data;
        end
    end
`endif

    assign data_o     = r_byte;
    assign valid_o    = r_valid;
    assign busy_o     = r_busy;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_bridge_tx.sv
// Self-checking bench for bridge_tx: directed frames plus random traffic vs a queue-based model.
module tb_bridge_tx;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        overflow_o;

    int n_chk = 0;
    int n_err = 0;

`ifdef BRIDGE_TX_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    bridge_tx dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Model: queue of bytes still owed on the wire, plus an optional held read.
    byte_q_t     mq;
    bit          m_pv;
    logic [15:0] m_pd;
    bit          m_ovf;
    bit          m_busy, m_last, m_cap;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic push_frame(input logic [15:0] d);
        mq.push_back(8'h4D);
        mq.push_back(hexc(d[15:12]));
        mq.push_back(hexc(d[11:8]));
        mq.push_back(hexc(d[7:4]));
        mq.push_back(hexc(d[3:0]));
        mq.push_back(8'h0D);
        mq.push_back(8'h0A);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pv  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_busy = (mq.size() != 0);
            m_last = 1'b0;
            m_cap  = valid_i && !rw_i;
            if (m_busy && ready_i) begin
                void'(mq.pop_front());
                m_last = (mq.size() == 0);
            end
            if (m_last) begin
                if (m_pv) begin
                    push_frame(m_pd);
                    m_pv = 1'b0;
                    if (m_cap) begin
                        m_pv  = 1'b1;
                        m_pd  = data_i;
                        m_cap = 1'b0;
                    end
                end else if (m_cap) begin
                    push_frame(data_i);
                    m_cap = 1'b0;
                end
            end
            if (m_cap) begin
                if (!m_busy)             push_frame(data_i);
                else if (PEND && !m_pv) begin m_pv = 1'b1; m_pd = data_i; end
                else                     m_ovf = 1'b1;
            end
        end
    end

    byte_q_t log_q;

    // Drive one cycle of inputs, log any transfer, then compare outputs against the model.
    task automatic cyc(input bit r, input bit v, input bit w, input logic [15:0] d, input bit rd);
        bit          hold;
        logic [7:0]  hd;
        rst = r; valid_i = v; rw_i = w; data_i = d; ready_i = rd;
        if (!r && valid_o && rd) log_q.push_back(data_o);
        hold = !r && valid_o && !rd;
        hd   = data_o;
        @(negedge clk);
        chk("valid_o", {31'd0, valid_o}, {31'd0, mq.size() != 0});
        chk("data_o", {24'd0, data_o}, {24'd0, (mq.size() != 0) ? mq[0] : 8'h00});
        chk("busy_o", {31'd0, busy_o}, {31'd0, mq.size() != 0});
        chk("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
        if (hold) chk("hold", {24'd0, data_o}, {24'd0, hd});
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, rd);
    endtask

    task automatic chk_log(input string tag, input byte_q_t exp);
        chk({tag, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk(tag, {24'd0, log_q[i]}, {24'd0, exp[i]});
        log_q.delete();
    endtask

    byte_q_t exp;

    initial begin
        rst = 1'b1; valid_i = 1'b0; rw_i = 1'b0; data_i = 16'h0; ready_i = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

        // Single read
        cyc(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1);
        chk("first_M", {24'd0, data_o}, 32'h4D);
        idle(8, 1'b1);
        exp = '{8'h4D, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        chk_log("beef", exp);
        chk("beef_busy", {31'd0, busy_o}, 32'd0);

        // Write ignored
        cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
        chk("wr_valid", {31'd0, valid_o}, 32'd0);
        idle(4, 1'b1);
        chk("wr_busy", {31'd0, busy_o}, 32'd0);
        exp = '{};
        chk_log("write", exp);

        // Backpressure: ready pattern 1,0,0,1 repeating
        cyc(1'b0, 1'b1, 1'b0, 16'h0A5F, 1'b1);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, (i % 4 == 0) || (i % 4 == 3));
        exp = '{8'h4D, 8'h30, 8'h41, 8'h35, 8'h46, 8'h0D, 8'h0A};
        chk_log("bp", exp);

        // New read coincident with the LF transfer
        cyc(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        idle(6, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0001, 1'b1);
        chk("b2b_M", {24'd0, data_o}, 32'h4D);
        idle(8, 1'b1);
        exp = '{8'h4D, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A,
                8'h4D, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
        chk_log("b2b", exp);
        chk("b2b_ovf", {31'd0, overflow_o}, 32'd0);

        // Collision: second read three cycles after the first
        cyc(1'b0, 1'b1, 1'b0, 16'h1111, 1'b1);
        idle(2, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h2222, 1'b1);
        idle(16, 1'b1);
        if (PEND) exp = '{8'h4D, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A,
                          8'h4D, 8'h32, 8'h32, 8'h32, 8'h32, 8'h0D, 8'h0A};
        else      exp = '{8'h4D, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
        chk_log("coll", exp);
        chk("coll_ovf", {31'd0, overflow_o}, {31'd0, !PEND});
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Collision with a third read while the pending slot is full
        cyc(1'b0, 1'b1, 1'b0, 16'h1111, 1'b1);
        idle(2, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h2222, 1'b1);
        idle(1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h3333, 1'b1);
        idle(16, 1'b1);
        chk_log("coll3", exp);
        chk("coll3_ovf", {31'd0, overflow_o}, 32'd1);

        // Reset mid-frame
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h7777, 1'b1);
        idle(2, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 16'h4444, 1'b1);
        chk("mid_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_ovf", {31'd0, overflow_o}, 32'd0);
        log_q.delete();
        cyc(1'b0, 1'b1, 1'b0, 16'h00C3, 1'b1);
        idle(8, 1'b1);
        exp = '{8'h4D, 8'h30, 8'h30, 8'h43, 8'h33, 8'h0D, 8'h0A};
        chk_log("c3", exp);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) == 0),
                16'($urandom),
                ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
